// File: rtl/frame_buffer.sv
// Stereo-to-mono averaging capture into a two-bank ping-pong frame buffer.
// Each completed frame is streamed out oldest-first over valid/ready.
`timescale 1ns/1ps
module frame_buffer #(
  parameter int N_LOG2 = 5,
  parameter int W      = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         newsample,
  input  logic [W-1:0] left,
  input  logic [W-1:0] right,
  input  logic         out_ready,
  input  logic         clear_ovf,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_first,
  output logic         out_last,
  output logic         overflow
);
  localparam int N = 1 << N_LOG2;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  state_t              state, state_nx;
  logic [W-1:0]        mem [2][N];
  logic [1:0]          full;
  logic                wr_bank, rd_bank;
  logic [N_LOG2-1:0]   wr_idx, rd_idx;
  logic [W:0]          sum;
  logic [W-1:0]        mono;
  logic                handshake, release_bank, frame_done, other_free, drop, start_read;

  always_comb begin
    sum  = {left[W-1], left} + {right[W-1], right};
    mono = sum[W:1];
  end

  always_comb begin
    handshake    = (state == STREAM) && out_valid && out_ready;
    release_bank = handshake && (rd_idx == '1);
    frame_done   = newsample && (wr_idx == '1);
    // A bank released on this very edge already counts as free.
    other_free   = !full[~wr_bank] || (release_bank && (rd_bank == ~wr_bank));
    drop         = frame_done && !other_free;
    start_read   = (state == IDLE) && full[~wr_bank];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_read) state_nx = LOAD;
      LOAD:    state_nx = STREAM;
      STREAM:  if (handshake) state_nx = (rd_idx == '1) ? IDLE : LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (newsample) mem[wr_bank][wr_idx] <= mono;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full     <= '0;
      wr_bank  <= 1'b0;
      wr_idx   <= '0;
      overflow <= 1'b0;
    end else begin
      if (release_bank) full[rd_bank] <= 1'b0;
      if (newsample) wr_idx <= wr_idx + 1'b1;
      if (frame_done && other_free) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
      end
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_bank   <= 1'b0;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (start_read) begin
        rd_bank <= ~wr_bank;
        rd_idx  <= '0;
      end
      if (state == LOAD) begin
        out_data  <= mem[rd_bank][rd_idx];
        out_first <= (rd_idx == '0);
        out_last  <= (rd_idx == '1);
        out_valid <= 1'b1;
      end
      if (handshake) begin
        out_valid <= 1'b0;
        if (rd_idx != '1) rd_idx <= rd_idx + 1'b1;
      end
    end
  end
endmodule
